// File: rtl/fb_pkg.sv
// Shared frame-buffer types and default frame geometry.
// Imported by the write arbiter, its interface and the fill engine.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_NPIX = FB_W * FB_H;
  localparam int FB_AW   = 15;
  localparam int FB_DW   = 12;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle of capture, fill, host, error and RAM write-port signals.
// slave: arbiter side; master: the sources plus the RAM write port.
interface fb_write_arbiter_if
  import fb_pkg::*;
#(
  parameter int AW = FB_AW,
  parameter int DW = FB_DW
);

  logic          cap_valid;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;

  logic          fill_start;
  logic [DW-1:0] fill_color;
  logic          fill_busy;
  logic          fill_done;

  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_ack;

  logic          cap_err;
  logic          err_clr;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport slave (
    input  cap_valid, cap_addr, cap_data,
    input  fill_start, fill_color,
    input  host_req, host_addr, host_data,
    input  err_clr,
    output fill_busy, fill_done,
    output host_ack, cap_err,
    output wr_en, wr_addr, wr_data
  );

  modport master (
    output cap_valid, cap_addr, cap_data,
    output fill_start, fill_color,
    output host_req, host_addr, host_data,
    output err_clr,
    input  fill_busy, fill_done,
    input  host_ack, cap_err,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/fb_fill_engine.sv
// Frame fill engine: IDLE/FILL/DONE FSM, pixel counter, colour latch.
// go_i starts a fill; preempt_i stalls it; req/addr/data offer a write.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int AW   = FB_AW,
  parameter int DW   = FB_DW,
  parameter int NPIX = FB_NPIX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go_i,
  input  logic          preempt_i,
  input  logic [DW-1:0] color_i,
  output logic          req_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  fill_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  // The counter parks on LAST after the final write, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          color_d = color_i;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!preempt_i) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_o  = (state_q == FILL);
  assign addr_o = cnt_q;
  assign data_o = color_q;
  assign busy_o = (state_q == FILL);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: capture > fill > host, registered.
// Ports: clk, reset (async active-low), bus (fb_write_arbiter_if.slave).
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int AW   = FB_AW,
  parameter int DW   = FB_DW,
  parameter int NPIX = FB_NPIX
) (
  input logic               clk,
  input logic               reset,
  fb_write_arbiter_if.slave bus
);

  // One extra bit so NPIX == 2**AW still compares correctly.
  localparam logic [AW:0] NPIX_W = (AW+1)'(NPIX);

  logic          cap_ok;
  logic          cap_bad;
  logic          fill_req;
  logic          fill_win;
  logic          fill_busy;
  logic          fill_done;
  logic          host_ack;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          cap_err_q, cap_err_d;

  assign cap_ok  = bus.cap_valid &&
                   ({1'b0, bus.cap_addr} < NPIX_W);
  assign cap_bad = bus.cap_valid && !cap_ok;

  fb_fill_engine #(
    .AW   (AW),
    .DW   (DW),
    .NPIX (NPIX)
  ) u_fill (
    .clk       (clk),
    .reset     (reset),
    .go_i      (bus.fill_start),
    .preempt_i (cap_ok),
    .color_i   (bus.fill_color),
    .req_o     (fill_req),
    .addr_o    (fill_addr),
    .data_o    (fill_data),
    .busy_o    (fill_busy),
    .done_o    (fill_done)
  );

  // A dropped capture leaves the cycle free for fill or host.
  assign fill_win = fill_req && !cap_ok;
  // The host waits out a whole fill, even on cycles fill loses.
  assign host_ack = bus.host_req && !cap_ok && !fill_busy;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (1'b1)
      cap_ok: begin
        wr_en_d   = 1'b1;
        wr_addr_d = bus.cap_addr;
        wr_data_d = bus.cap_data;
      end
      fill_win: begin
        wr_en_d   = 1'b1;
        wr_addr_d = fill_addr;
        wr_data_d = fill_data;
      end
      host_ack: begin
        wr_en_d   = 1'b1;
        wr_addr_d = bus.host_addr;
        wr_data_d = bus.host_data;
      end
      default: ;
    endcase
  end

  // A new bad capture outranks a same-cycle clear.
  always_comb begin
    cap_err_d = cap_err_q;
    if (cap_bad) begin
      cap_err_d = 1'b1;
    end else if (bus.err_clr) begin
      cap_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cap_err_q <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cap_err_q <= cap_err_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cap_err   = cap_err_q;
  assign bus.host_ack  = host_ack;
  assign bus.fill_busy = fill_busy;
  assign bus.fill_done = fill_done;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table plus fill sequences.
// u_dut uses NPIX=16; u_big keeps full-frame NPIX for passthrough.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int AW = 15;
  localparam int DW = 12;
  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_write_arbiter_if #(.AW(AW), .DW(DW)) sif ();
  fb_write_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  fb_write_arbiter #(.AW(AW), .DW(DW), .NPIX(NP)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (sif)
  );

  fb_write_arbiter #(.AW(AW), .DW(DW), .NPIX(FB_NPIX)) u_big (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    sif.cap_valid = 1'b0; sif.cap_addr = '0; sif.cap_data = '0;
    sif.fill_start = 1'b0; sif.fill_color = '0;
    sif.host_req = 1'b0; sif.host_addr = '0; sif.host_data = '0;
    sif.err_clr = 1'b0;
    bif.cap_valid = 1'b0; bif.cap_addr = '0; bif.cap_data = '0;
    bif.fill_start = 1'b0; bif.fill_color = '0;
    bif.host_req = 1'b0; bif.host_addr = '0; bif.host_data = '0;
    bif.err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          cv;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          hr;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          clr;
    logic          ack;
    logic          en;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          err;
  } vec_t;

  vec_t vt[12];

  int fcnt[NP];
  int cap2_cyc, cap3_cyc, host_cyc, ack_cyc, done_cyc;
  int ndone, other, nwr, last_fill;
  logic acked;

  initial begin
    vt[0]  = '{1'b1, 15'd3, 12'h111, 1'b0, 15'd0, 12'h000, 1'b0,
               1'b0, 1'b1, 15'd3, 12'h111, 1'b0};
    vt[1]  = '{1'b0, 15'd0, 12'h000, 1'b0, 15'd0, 12'h000, 1'b0,
               1'b0, 1'b0, 15'd3, 12'h111, 1'b0};
    vt[2]  = '{1'b0, 15'd0, 12'h000, 1'b1, 15'd9, 12'h222, 1'b0,
               1'b1, 1'b1, 15'd9, 12'h222, 1'b0};
    vt[3]  = '{1'b1, 15'd4, 12'h333, 1'b1, 15'd9, 12'h222, 1'b0,
               1'b0, 1'b1, 15'd4, 12'h333, 1'b0};
    vt[4]  = '{1'b0, 15'd0, 12'h000, 1'b1, 15'd9, 12'h222, 1'b0,
               1'b1, 1'b1, 15'd9, 12'h222, 1'b0};
    vt[5]  = '{1'b1, 15'd16, 12'h444, 1'b1, 15'd5, 12'h0F0, 1'b0,
               1'b1, 1'b1, 15'd5, 12'h0F0, 1'b1};
    vt[6]  = '{1'b0, 15'd0, 12'h000, 1'b0, 15'd0, 12'h000, 1'b0,
               1'b0, 1'b0, 15'd5, 12'h0F0, 1'b1};
    vt[7]  = '{1'b1, 15'd20, 12'h777, 1'b0, 15'd0, 12'h000, 1'b1,
               1'b0, 1'b0, 15'd5, 12'h0F0, 1'b1};
    vt[8]  = '{1'b0, 15'd0, 12'h000, 1'b0, 15'd0, 12'h000, 1'b1,
               1'b0, 1'b0, 15'd5, 12'h0F0, 1'b0};
    vt[9]  = '{1'b1, 15'd15, 12'h555, 1'b0, 15'd0, 12'h000, 1'b0,
               1'b0, 1'b1, 15'd15, 12'h555, 1'b0};
    vt[10] = '{1'b1, 15'h7FFF, 12'h666, 1'b0, 15'd0, 12'h000, 1'b0,
               1'b0, 1'b0, 15'd15, 12'h555, 1'b1};
    vt[11] = '{1'b0, 15'd0, 12'h000, 1'b1, 15'd1, 12'h0AB, 1'b1,
               1'b1, 1'b1, 15'd1, 12'h0AB, 1'b0};

    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst wr_en", 32'(sif.wr_en), 32'd0);
    chk("rst wr_addr", 32'(sif.wr_addr), 32'd0);
    chk("rst wr_data", 32'(sif.wr_data), 32'd0);
    chk("rst busy", 32'(sif.fill_busy), 32'd0);
    chk("rst done", 32'(sif.fill_done), 32'd0);
    chk("rst cap_err", 32'(sif.cap_err), 32'd0);
    chk("rst host_ack", 32'(sif.host_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of capture traffic.
    tick();
    bif.cap_valid = 1'b1; bif.cap_addr = 15'h050; bif.cap_data = 12'h777;
    tick();
    chk("traffic wr_en", 32'(bif.wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst wr_en", 32'(bif.wr_en), 32'd0);
    chk("midrst wr_addr", 32'(bif.wr_addr), 32'd0);
    chk("midrst wr_data", 32'(bif.wr_data), 32'd0);
    chk("midrst cap_err", 32'(bif.cap_err), 32'd0);
    bif.cap_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bif.cap_valid = 1'b1; bif.cap_addr = 15'h0123; bif.cap_data = 12'hABC;
    tick();
    bif.cap_valid = 1'b0;
    chk("pass wr_en", 32'(bif.wr_en), 32'd1);
    chk("pass wr_addr", 32'(bif.wr_addr), 32'h0123);
    chk("pass wr_data", 32'(bif.wr_data), 32'hABC);
    tick();
    chk("pass wr_en off", 32'(bif.wr_en), 32'd0);
    chk("pass addr hold", 32'(bif.wr_addr), 32'h0123);

    // Single-cycle arbitration vectors, no fill running.
    for (int i = 0; i < 12; i++) begin
      sif.cap_valid = vt[i].cv;
      sif.cap_addr = vt[i].ca;
      sif.cap_data = vt[i].cd;
      sif.host_req = vt[i].hr;
      sif.host_addr = vt[i].ha;
      sif.host_data = vt[i].hd;
      sif.err_clr = vt[i].clr;
      #1;
      chk($sformatf("v%0d ack", i), 32'(sif.host_ack), 32'(vt[i].ack));
      tick();
      chk($sformatf("v%0d wr_en", i), 32'(sif.wr_en), 32'(vt[i].en));
      chk($sformatf("v%0d wr_addr", i), 32'(sif.wr_addr), 32'(vt[i].wa));
      chk($sformatf("v%0d wr_data", i), 32'(sif.wr_data), 32'(vt[i].wd));
      chk($sformatf("v%0d cap_err", i), 32'(sif.cap_err), 32'(vt[i].err));
      idle_in();
    end
    tick();

    // Fill: captures in cycles 3,4; host waits; restarts ignored.
    for (int a = 0; a < NP; a++) fcnt[a] = 0;
    cap2_cyc = -1; cap3_cyc = -1; host_cyc = -1; ack_cyc = -1;
    done_cyc = -1; ndone = 0; other = 0; nwr = 0; last_fill = -1;
    acked = 1'b0;
    sif.fill_start = 1'b1;
    sif.fill_color = 12'hF00;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (sif.wr_en) begin
        nwr++;
        if (sif.wr_data == 12'hF00 && 32'(sif.wr_addr) < NP) begin
          fcnt[sif.wr_addr[3:0]]++;
          last_fill = k;
        end else if (sif.wr_addr == 15'd2 && sif.wr_data == 12'hC02) begin
          cap2_cyc = k;
        end else if (sif.wr_addr == 15'd3 && sif.wr_data == 12'hC03) begin
          cap3_cyc = k;
        end else if (sif.wr_addr == 15'd5 && sif.wr_data == 12'h0F0) begin
          host_cyc = k;
        end else begin
          other++;
        end
      end
      chk($sformatf("fill busy c%0d", k), 32'(sif.fill_busy),
          32'(k >= 1 && k <= 18));
      if (sif.fill_done) begin
        ndone++;
        done_cyc = k;
      end
      sif.fill_start = (k == 8 || k == 19);
      sif.fill_color = (k == 8 || k == 19) ? 12'h00F : 12'hF00;
      sif.cap_valid = (k == 3 || k == 4);
      sif.cap_addr = (k == 3) ? 15'd2 : 15'd3;
      sif.cap_data = (k == 3) ? 12'hC02 : 12'hC03;
      sif.host_req = (k >= 2) && !acked;
      sif.host_addr = 15'd5;
      sif.host_data = 12'h0F0;
      #1;
      if (k >= 2 && k <= 20)
        chk($sformatf("stall ack c%0d", k), 32'(sif.host_ack),
            32'(k == 19));
      if (sif.host_ack) begin
        acked = 1'b1;
        ack_cyc = k;
      end
    end
    for (int a = 0; a < NP; a++)
      chk($sformatf("fill addr %0d count", a), 32'(fcnt[a]), 32'd1);
    chk("fill last write cycle", 32'(last_fill), 32'd19);
    chk("cap2 write cycle", 32'(cap2_cyc), 32'd4);
    chk("cap3 write cycle", 32'(cap3_cyc), 32'd5);
    chk("host ack cycle", 32'(ack_cyc), 32'd19);
    chk("host write cycle", 32'(host_cyc), 32'd20);
    chk("fill stray writes", 32'(other), 32'd0);
    chk("fill total writes", 32'(nwr), 32'd19);
    chk("fill_done count", 32'(ndone), 32'd1);
    chk("fill_done cycle", 32'(done_cyc), 32'd19);
    idle_in();
    tick();

    // Reset while fill_cnt is 7.
    sif.fill_start = 1'b1;
    sif.fill_color = 12'h0A5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      sif.fill_start = 1'b0;
    end
    chk("pre-rst wr_addr", 32'(sif.wr_addr), 32'd6);
    chk("pre-rst busy", 32'(sif.fill_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("fillrst busy", 32'(sif.fill_busy), 32'd0);
    chk("fillrst done", 32'(sif.fill_done), 32'd0);
    chk("fillrst wr_en", 32'(sif.wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sif.fill_done) ndone++;
    end
    chk("aborted fill_done", 32'(ndone), 32'd0);
    sif.fill_start = 1'b1;
    sif.fill_color = 12'h5A5;
    tick();
    sif.fill_start = 1'b0;
    chk("restart busy", 32'(sif.fill_busy), 32'd1);
    tick();
    chk("restart wr_en", 32'(sif.wr_en), 32'd1);
    chk("restart wr_addr", 32'(sif.wr_addr), 32'd0);
    chk("restart wr_data", 32'(sif.wr_data), 32'h5A5);
    ndone = 0;
    for (int k = 0; k < 40 && ndone == 0; k++) begin
      tick();
      if (sif.fill_done) ndone++;
    end
    chk("restart fill_done", 32'(ndone), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Single-clock write-port controller for the dual-port frame buffer RAM. It shares the buffer's one write port between three sources, in fixed priority order:
- the camera capture stream, which is never stalled;
- an internal fill engine that clears or paints the whole frame to one colour;
- a host (test/debug) requester using a req/ack handshake.

Its registered outputs drive the buffer's address, data and write-enable inputs directly. The read/display side is untouched.

## Interface
- AW, 15, address width; matches the frame buffer.
- DW, 12, pixel width (RGB444).
- NPIX, 19200, number of valid pixel addresses (160x120); addresses 0..NPIX-1.
- clk  in  1  system clock; also clocks the frame buffer write port.
- reset  in  1  asynchronous, active-low reset.
- cap_valid  in  1  capture pixel valid, one pixel per cycle.
- cap_addr  in  AW  capture pixel address.
- cap_data  in  DW  capture pixel data.
- fill_start  in  1  one-cycle pulse; start a frame fill.
- fill_color  in  DW  fill colour; sampled on an accepted fill_start.
- fill_busy  out  1  high while the fill engine is in FILL.
- fill_done  out  1  one-cycle pulse when the fill completes.
- host_req  in  1  host write request; held until acked.
- host_addr  in  AW  host write address; stable while host_req is high.
- host_data  in  DW  host write data; stable while host_req is high.
- host_ack  out  1  combinational grant; the write is taken on this clock edge.
- cap_err  out  1  sticky flag: a capture address was >= NPIX.
- err_clr  in  1  clears cap_err.
- wr_en  out  1  frame buffer write enable (buffer's regwrite).
- wr_addr  out  AW  frame buffer write address (buffer's addr_in).
- wr_data  out  DW  frame buffer write data (buffer's data_in).

## Operation
- Each cycle, at most one source wins the port.
- Priority: capture > fill > host.
- Capture:
  - A cap_valid cycle with cap_addr < NPIX always wins.
  - If cap_addr >= NPIX, the pixel is dropped, no write is issued, and cap_err sets. That cycle is free for fill or host.
- Fill engine FSM, states IDLE, FILL, DONE:
  - IDLE: on fill_start, latch fill_color, clear fill_cnt to 0, go to FILL. fill_start in any other state is ignored.
  - FILL: when not pre-empted by capture, write fill_cnt with the latched colour and increment. After the write at NPIX-1, go to DONE. When pre-empted, fill_cnt holds.
  - DONE: fill_done=1 for one cycle, then IDLE.
- Host:
  - host_ack = host_req AND no winning capture AND state != FILL.
  - The host is stalled for the entire fill. This is intentional and is the host's responsibility.
  - After an ack, a still-high host_req on the next cycle is a new write.
- cap_err:
  - Sets on any out-of-range capture and holds until err_clr.
  - Simultaneous set and err_clr: set wins.
- fill_cnt is AW bits wide. Comparisons against NPIX-1 are unsigned. NPIX <= 2^AW is required; fill_cnt never wraps.

## Timing
- Reset (async assert, sync release):
  - wr_en=0, wr_addr=0, wr_data=0;
  - state=IDLE, fill_cnt=0;
  - fill_busy=0, fill_done=0, cap_err=0;
  - host_ack follows its equation (0 unless host_req).
- Reset mid-fill aborts the fill with no fill_done. The partially written frame is left as-is.
- wr_en, wr_addr and wr_data are registered. A winning source in cycle n drives them in cycle n+1, and the RAM writes at the end of n+1. Latency from source to RAM write is 2 edges.
- wr_en=0 in any cycle with no winner. wr_addr and wr_data hold their last values.
- fill_busy is registered, equal to (state==FILL).
- Fill with no capture traffic:
  - start pulse at cycle 0;
  - FILL from cycle 1;
  - writes in cycles 1..NPIX, appearing on wr_* in cycles 2..NPIX+1;
  - fill_done in cycle NPIX+1.
  - Each pre-empted cycle adds 1 cycle.
- fill_start in the same cycle as DONE is ignored.

## Structure
- Shared package `fb_pkg` holds:
  - fill FSM state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2);
  - default frame constants FB_W=160, FB_H=120, FB_NPIX, FB_AW=15, FB_DW=12.
- Sub-module `fb_fill_engine` contains the FSM, fill_cnt and the colour latch. Ports: go, pre-empt, req, addr, data, busy, done.
- The top level holds the priority mux, the output registers and cap_err.

## Test plan
- Reset and passthrough:
  - Stimulus: assert reset low mid-traffic, release, then cap_valid with addr 0x0123, data 0xABC.
  - Required: all outputs at reset values; wr_en=1, wr_addr=0x0123, wr_data=0xABC exactly one cycle after cap_valid.
- Fill:
  - Stimulus: NPIX=16, fill_start with colour 0xF00, cap_valid asserted in cycles 3 and 4.
  - Required: addresses 0..15 each written once with 0xF00; the capture writes are interleaved; fill_done in cycle 19.
- Host stall:
  - Stimulus: host_req at addr 5, data 0x0F0, during a fill.
  - Required: host_ack=0 until state is IDLE; then ack for one cycle; wr_addr=5, wr_data=0x0F0 on the next cycle.
- Capture error:
  - Stimulus: cap_valid with addr NPIX, host_req high in the same cycle.
  - Required: no write for the capture; cap_err=1; host acked that cycle. Then err_clr together with another bad capture leaves cap_err=1.
- Ignored start:
  - Stimulus: fill_start pulse mid-fill with colour 0x00F.
  - Required: the fill continues with the original colour; exactly one fill_done.
- Reset mid-fill:
  - Stimulus: reset at fill_cnt=7.
  - Required: fill_busy=0 immediately; no fill_done; the next fill_start restarts at address 0.
